// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one data-memory port of dmem_arbiter.
// master = requester (cpu or dbg), slave = arbiter.
interface dmem_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;

   modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
   modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the cpu
// load/store path and the dbg loader, with a bounded hold count per owner.
module dmem_arbiter #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAX_HOLD   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   dmem_arbiter_if.slave         cpu,
   dmem_arbiter_if.slave         dbg,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned     HOLD_W    = 4;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_CPU = 2'd1,
      OWN_DBG = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              last_is_dbg;
   logic              contested;

   // Owner is being granted while the other port waits
   assign contested = (state == OWN_CPU && cpu.req && dbg.req) ||
                      (state == OWN_DBG && dbg.req && cpu.req);

   // State register with hold counter and round-robin history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         last_is_dbg <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            hold_cnt <= '0;
            if (state_nxt == OWN_CPU) last_is_dbg <= 1'b0;
            if (state_nxt == OWN_DBG) last_is_dbg <= 1'b1;
         end else if (contested) begin
            hold_cnt <= (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);
         end else begin
            hold_cnt <= '0;
         end
      end
   end

   // Next-state: hand over on release or when the hold budget is spent
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cpu.req && dbg.req) state_nxt = last_is_dbg ? OWN_CPU : OWN_DBG;
            else if (cpu.req)       state_nxt = OWN_CPU;
            else if (dbg.req)       state_nxt = OWN_DBG;
         end
         OWN_CPU: begin
            if (!cpu.req)                              state_nxt = dbg.req ? OWN_DBG : IDLE;
            else if (dbg.req && hold_cnt == HOLD_LAST) state_nxt = OWN_DBG;
         end
         OWN_DBG: begin
            if (!dbg.req)                              state_nxt = cpu.req ? OWN_CPU : IDLE;
            else if (cpu.req && hold_cnt == HOLD_LAST) state_nxt = OWN_CPU;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Owner mux onto the memory pins; enables only while the owner requests
   always_comb begin
      cpu.gnt   = 1'b0;
      dbg.gnt   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      case (state)
         OWN_CPU: begin
            cpu.gnt   = cpu.req;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
            mem_we    = cpu.req & cpu.we;
            mem_re    = cpu.req & ~cpu.we;
         end
         OWN_DBG: begin
            dbg.gnt   = dbg.req;
            mem_addr  = dbg.addr;
            mem_wdata = dbg.wdata;
            mem_we    = dbg.req & dbg.we;
            mem_re    = dbg.req & ~dbg.we;
         end
         default: ;
      endcase
   end

   // Read-data capture; rdata holds until that port's next read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu.rdata  <= '0;
         cpu.rvalid <= 1'b0;
         dbg.rdata  <= '0;
         dbg.rvalid <= 1'b0;
      end else begin
         cpu.rvalid <= cpu.gnt & ~cpu.we;
         dbg.rvalid <= dbg.gnt & ~dbg.we;
         if (cpu.gnt && !cpu.we) cpu.rdata <= mem_rdata;
         if (dbg.gnt && !dbg.we) dbg.rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against an ownership/run-length model and a shadow memory.
module tb_dmem_arbiter;

   localparam int unsigned DW       = 16;
   localparam int unsigned AW       = 16;
   localparam int unsigned MAX_HOLD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;

   dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cpu_if ();
   dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dbg_if ();

   dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu       (cpu_if),
      .dbg       (dbg_if),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Stand-in for DataMemory: combinational read, write at rising edge
   logic [DW-1:0] tbmem [256];
   assign mem_rdata = tbmem[mem_addr[7:0]];
   always @(posedge clk) if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
   endtask

   // Reference model: owner 0 = none, 1 = cpu, 2 = dbg
   int            m_owner, m_run, m_last;
   logic [DW-1:0] shadow [256];
   logic          exp_rvalid [3];
   logic [DW-1:0] exp_rdata [3];

   function automatic logic rq(int p); return (p == 1) ? cpu_if.req : dbg_if.req; endfunction
   function automatic logic wq(int p); return (p == 1) ? cpu_if.we  : dbg_if.we;  endfunction
   function automatic logic [AW-1:0] aq(int p); return (p == 1) ? cpu_if.addr  : dbg_if.addr;  endfunction
   function automatic logic [DW-1:0] dq(int p); return (p == 1) ? cpu_if.wdata : dbg_if.wdata; endfunction
   function automatic logic exp_gnt(int p); return (m_owner == p) && rq(p); endfunction

   task automatic model_reset();
      m_owner = 0; m_run = 0; m_last = 2;
      for (int p = 0; p < 3; p++) begin exp_rvalid[p] = 1'b0; exp_rdata[p] = '0; end
   endtask

   // One clock edge of the model, using the inputs present before the edge
   task automatic model_advance();
      int o = m_owner;
      int x;
      for (int p = 0; p < 3; p++) exp_rvalid[p] = 1'b0;
      if (o != 0 && rq(o)) begin
         if (wq(o)) shadow[aq(o)[7:0]] = dq(o);
         else begin exp_rdata[o] = shadow[aq(o)[7:0]]; exp_rvalid[o] = 1'b1; end
      end
      if (o == 0) begin
         if (rq(1) && rq(2)) m_owner = (m_last == 1) ? 2 : 1;
         else if (rq(1))     m_owner = 1;
         else if (rq(2))     m_owner = 2;
         m_run = 0;
      end else begin
         x = 3 - o;
         if (!rq(o)) begin
            m_owner = rq(x) ? x : 0;
            m_run = 0;
         end else if (rq(x)) begin
            m_run++;
            if (m_run >= int'(MAX_HOLD)) begin m_owner = x; m_run = 0; end
         end else m_run = 0;
      end
      if (m_owner != 0 && m_owner != o) m_last = m_owner;
   endtask

   task automatic set_port(input int p, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 1) begin cpu_if.req = r; cpu_if.we = w; cpu_if.addr = a; cpu_if.wdata = d; end
      else        begin dbg_if.req = r; dbg_if.we = w; dbg_if.addr = a; dbg_if.wdata = d; end
   endtask

   task automatic check_outputs();
      logic gc, gd, ew, er;
      gc = exp_gnt(1); gd = exp_gnt(2);
      ew = (gc & cpu_if.we) | (gd & dbg_if.we);
      er = (gc & ~cpu_if.we) | (gd & ~dbg_if.we);
      check("cpu_gnt", 32'(cpu_if.gnt), 32'(gc));
      check("dbg_gnt", 32'(dbg_if.gnt), 32'(gd));
      check("mem_we", 32'(mem_we), 32'(ew));
      check("mem_re", 32'(mem_re), 32'(er));
      check("cpu_rvalid", 32'(cpu_if.rvalid), 32'(exp_rvalid[1]));
      check("dbg_rvalid", 32'(dbg_if.rvalid), 32'(exp_rvalid[2]));
      check("cpu_rdata", 32'(cpu_if.rdata), 32'(exp_rdata[1]));
      check("dbg_rdata", 32'(dbg_if.rdata), 32'(exp_rdata[2]));
      if (gc || gd) check("mem_addr", 32'(mem_addr), 32'(gc ? cpu_if.addr : dbg_if.addr));
      if (ew) check("mem_wdata", 32'(mem_wdata), 32'(gc ? cpu_if.wdata : dbg_if.wdata));
   endtask

   task automatic check_reset_vals();
      check("rst_cpu_gnt", 32'(cpu_if.gnt), 32'd0);
      check("rst_dbg_gnt", 32'(dbg_if.gnt), 32'd0);
      check("rst_cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
      check("rst_dbg_rvalid", 32'(dbg_if.rvalid), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_if.rdata), 32'd0);
      check("rst_dbg_rdata", 32'(dbg_if.rdata), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
   endtask

   // One cycle: inputs already driven; check mid-cycle, then advance model
   task automatic cyc();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      set_port(1, 1'b0, 1'b0, '0, '0);
      set_port(2, 1'b0, 1'b0, '0, '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int            i, cnt_c, cnt_d;
      logic          g;
      logic [11:0]   pattern;
      logic          pend [3];
      logic          gsave [3];

      for (int k = 0; k < 256; k++) begin tbmem[k] <= '0; shadow[k] = '0; end
      tbmem[16] <= 16'h1234;
      shadow[16] = 16'h1234;
      do_reset();

      // Single cpu read from idle
      set_port(1, 1'b1, 1'b0, 16'h0010, '0);
      cyc();
      cyc();
      set_port(1, 1'b0, 1'b0, 16'h0010, '0);
      check("rd0010_rdata", 32'(cpu_if.rdata), 32'h1234);
      cyc();
      cyc();

      // Both request after reset: cpu first, then dbg reads back 0x00AA
      do_reset();
      set_port(1, 1'b1, 1'b1, 16'h0004, 16'h00AA);
      set_port(2, 1'b1, 1'b0, 16'h0004, '0);
      cyc(); cyc(); cyc();
      set_port(1, 1'b0, 1'b0, '0, '0);
      cyc();
      g = dbg_if.gnt;
      check("handover_dbg_gnt", 32'(g), 32'd1);
      cyc();
      set_port(2, 1'b0, 1'b0, '0, '0);
      check("handover_dbg_rdata", 32'(dbg_if.rdata), 32'h00AA);
      cyc();

      // Continuous contention: runs of MAX_HOLD
      set_port(1, 1'b1, 1'b0, 16'h0010, '0);
      set_port(2, 1'b1, 1'b0, 16'h0004, '0);
      cyc();
      pattern = '0;
      for (int k = 0; k < 12; k++) begin
         pattern = {pattern[10:0], cpu_if.gnt};
         cyc();
      end
      check("rr_pattern", 32'(pattern), 32'b1111_0000_1111);
      set_port(1, 1'b0, 1'b0, '0, '0);
      set_port(2, 1'b0, 1'b0, '0, '0);
      cyc();

      // dbg streams 10 writes alone
      i = 0; cnt_d = 0;
      set_port(2, 1'b1, 1'b1, 16'(0), 16'h0100);
      for (int c = 0; c < 40 && i < 10; c++) begin
         g = exp_gnt(2);
         cyc();
         cnt_d++;
         if (g) begin
            i++;
            if (i < 10) set_port(2, 1'b1, 1'b1, 16'(i), 16'h0100 + 16'(i));
            else        set_port(2, 1'b0, 1'b0, '0, '0);
         end
      end
      check("dbg_stream_done", 32'(i), 32'd10);
      check("dbg_stream_cycles", 32'(cnt_d), 32'd11);
      for (int j = 0; j < 10; j++) begin
         set_port(1, 1'b1, 1'b0, 16'(j), '0);
         g = 1'b0;
         for (int c = 0; c < 10 && !g; c++) begin
            g = exp_gnt(1);
            cyc();
         end
         check("readback_gnt", 32'(g), 32'd1);
         check("readback_data", 32'(cpu_if.rdata), 32'h0100 + 32'(j));
      end
      set_port(1, 1'b0, 1'b0, '0, '0);
      cyc();

      // cpu blips one cycle while dbg streams below its hold limit
      i = 0; cnt_c = 0; cnt_d = 0;
      set_port(2, 1'b1, 1'b1, 16'h0020, 16'h0200);
      for (int c = 0; c < 40 && i < 10; c++) begin
         set_port(1, (i == 2) && (cnt_d == 2), 1'b0, 16'h0010, '0);
         g = exp_gnt(2);
         cnt_c += int'(cpu_if.gnt);
         cyc();
         if (g) begin
            i++;
            cnt_d++;
            if (i < 10) set_port(2, 1'b1, 1'b1, 16'h0020 + 16'(i), 16'h0200 + 16'(i));
            else        set_port(2, 1'b0, 1'b0, '0, '0);
         end
      end
      set_port(1, 1'b0, 1'b0, '0, '0);
      check("blip_cpu_gnts", 32'(cnt_c), 32'd0);
      check("blip_dbg_gnts", 32'(cnt_d), 32'd10);
      cyc();

      // Reset during a granted cpu write: nothing commits
      set_port(1, 1'b1, 1'b1, 16'h0008, 16'hBEEF);
      cyc();
      #2;
      check("midrst_pre_we", 32'(mem_we), 32'd1);
      reset = 1'b0;
      model_reset();
      #1;
      check("midrst_we_drop", 32'(mem_we), 32'd0);
      check("midrst_gnt_drop", 32'(cpu_if.gnt), 32'd0);
      @(posedge clk);
      #1;
      check("midrst_mem8", 32'(tbmem[8]), 32'h0108);
      check_reset_vals();
      set_port(1, 1'b0, 1'b0, '0, '0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic obeying the hold-until-grant rule
      pend[1] = 1'b0; pend[2] = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         for (int p = 1; p < 3; p++) begin
            if (!pend[p]) begin
               if ($urandom_range(9) < 7)
                  set_port(p, 1'b1, 1'($urandom_range(1)), 16'($urandom_range(255)), 16'($urandom));
               else
                  set_port(p, 1'b0, 1'b0, '0, '0);
               pend[p] = rq(p);
            end else if ($urandom_range(19) == 0) begin
               set_port(p, 1'b0, 1'b0, '0, '0);
               pend[p] = 1'b0;
            end
            gsave[p] = exp_gnt(p);
         end
         cyc();
         for (int p = 1; p < 3; p++) if (gsave[p]) pend[p] = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor load/store path (cpu) and a switch/debug loader port (dbg).
- Registered round-robin arbiter with a bounded hold count, so neither port starves.
- Sits between the processor datapath and DataMemory and drives that memory's address, write-data and enable pins.
- The cpu port stalls by watching cpu_gnt.

Parameters:
DATA_WIDTH, 16, width of memory data words
ADDR_WIDTH, 16, width of memory addresses
MAX_HOLD, 4, maximum consecutive granted accesses by one owner while the other port is requesting (range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; clears all state
cpu_req  input  1  cpu requests a memory access this cycle
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_WIDTH  cpu access address
cpu_wdata  input  DATA_WIDTH  cpu write data
cpu_gnt  output  1  cpu access performed at the coming edge
cpu_rdata  output  DATA_WIDTH  registered read data for cpu
cpu_rvalid  output  1  cpu_rdata valid, one-cycle pulse
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rdata, dbg_rvalid: same widths and meanings as the cpu_* ports, for the dbg port
mem_addr  output  ADDR_WIDTH  to DataMemory MemAddr
mem_wdata  output  DATA_WIDTH  to DataMemory MemWriteData
mem_we  output  1  to DataMemory MemWriteEnable
mem_re  output  1  to DataMemory MemReadEnable
mem_rdata  input  DATA_WIDTH  from DataMemory MemReadData (combinational read)

Behaviour:
- Reset values (while reset low):
  - state = IDLE, hold_cnt = 0, last_owner = DBG.
  - All gnt, rvalid, mem_we and mem_re = 0.
  - rdata registers and mem_addr/mem_wdata = 0.
- States:
  - IDLE: no owner, no grant, memory pins idle.
  - OWN_CPU / OWN_DBG: owner's inputs muxed onto mem_* combinationally.
- Grant and memory enables:
  - x_gnt = (state == OWN_x) & x_req.
  - mem_we = gnt & we; mem_re = gnt & ~we.
  - A write commits at the rising edge ending the granted cycle.
- Read data:
  - On a granted read, mem_rdata is captured into x_rdata at that edge.
  - x_rvalid = 1 for exactly the next cycle.
  - x_rdata holds its value until the next read by the same port.
- Transitions, evaluated each edge:
  - IDLE, only one port requesting -> that port's OWN state.
  - IDLE, both requesting -> the port that is not last_owner.
  - OWN_x, x_req dropped: if the other port is requesting, go to its OWN state; otherwise go to IDLE.
  - OWN_x, x_req held, other port requesting, hold_cnt == MAX_HOLD-1 -> switch to the other port's OWN state.
  - OWN_x, x_req held, otherwise -> stay.
- Request-to-grant latency:
  - From IDLE: req at cycle n -> gnt at cycle n+1; read data valid at cycle n+2.
  - At a handover the new owner is granted in the first cycle of its OWN state, with no bubble.
- hold_cnt:
  - Increments on each granted cycle while the other port is requesting.
  - Clears on any state change, and whenever the other port is not requesting.
  - Saturates; never wraps.
- last_owner: updated to x on every entry to OWN_x.
- Requester obligations:
  - Keep req, we, addr and wdata stable until gnt is seen.
  - Dropping req before gnt is legal; no access occurs.
- Reset mid-access: mem_we is forced 0 asynchronously, so a pending write does not commit; rvalid clears and the state returns to IDLE.
- Granted-request mux: mem_addr/mem_wdata follow the owner's inputs even when gnt is 0. This is harmless because the enables are 0.

Test Plan:
- Reset release, then cpu_req read addr 0x0010, memory holds 0x1234:
  - cpu_gnt high in cycle 1 only, mem_re = 1.
  - cpu_rvalid in cycle 2 with cpu_rdata = 0x1234.
  - dbg ports stay 0.
- Both ports request from IDLE just after reset:
  - cpu granted first (last_owner = DBG).
  - cpu writes 0x00AA to 0x0004 for 2 cycles then drops req.
  - dbg is granted on the next cycle with no bubble.
- Both ports hold req continuously, MAX_HOLD = 4:
  - Grants alternate in runs of 4: cpu x4, dbg x4, cpu x4.
  - Exactly one gnt high per cycle; mem_we never asserted without a gnt.
- dbg alone streams 10 writes (addr 0..9, data 0x0100+i):
  - dbg_gnt stays high all 10 cycles; hold_cnt stays 0.
  - Readback via cpu returns 0x0100..0x0109.
- Reset pulled low in the same cycle as a granted cpu write of 0xBEEF to 0x0008:
  - mem_we drops immediately; location 0x0008 keeps its old value.
  - All outputs return to reset values.
- cpu raises req for one cycle while dbg owns the memory and dbg is not at its hold limit, then cpu drops req:
  - No cpu_gnt, no cpu_rvalid.
  - The dbg run continues uninterrupted.
